// File: rtl/fifo_bank.sv
// fifo_bank: single-clock, multi-lane, lock-step FIFO with one shared handshake.
// Every lane is written and read together, so paired streams (I/Q, L/R) can
// never slip relative to each other.
//
// Optional build macro: FIFO_BANK_FWFT_EN selects first-word fall-through reads.
// If the macro is not defined, reads are standard registered reads.
//
// Ports:
//   clk          - sole clock, rising edge
//   reset        - synchronous, active-low
//   wr_en, din   - write request / packed lane data (lane k at [k*DATA_WIDTH +: DATA_WIDTH])
//   full         - count == DEPTH
//   almost_full  - count >= AF_THRESH
//   rd_en        - read request (acknowledge in FWFT mode)
//   dout         - packed read data, same lane packing as din
//   empty        - no readable data
//   count        - stored entries (includes the output stage in FWFT mode)
//   err_clr      - clears sticky error flags (a same-cycle error event wins)
//   overflow     - sticky: write attempted while full
//   underflow    - sticky: read attempted while empty
module fifo_bank #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0] din,
  output logic                           full,
  output logic                           almost_full,
  input  logic                           rd_en,
  output logic [CHANNELS*DATA_WIDTH-1:0] dout,
  output logic                           empty,
  output logic [$clog2(DEPTH):0]         count,
  input  logic                           err_clr,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int W  = CHANNELS * DATA_WIDTH;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0] AF_C    = (PW+1)'(AF_THRESH);
  localparam logic [PW:0] ONE_C   = (PW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;
  logic          mem_wr;
  logic          mem_rd;
  logic [PW:0]   count_nxt;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + ONE_C;
      2'b01:   count_nxt = count - ONE_C;
      default: count_nxt = count;
    endcase
  end

`ifdef FIFO_BANK_FWFT_EN
  // The output register is one more storage slot; the memory holds the rest.
  // A write into an empty bank bypasses memory straight into the output stage
  // so data is visible the cycle after the write.
  logic        out_valid;
  logic        out_valid_nxt;
  logic        out_load;
  logic        bypass;
  logic [PW:0] mem_cnt;

  always_comb begin
    mem_cnt       = count - {{PW{1'b0}}, out_valid};
    out_load      = ~out_valid | rd_acc;
    mem_rd        = out_load & (mem_cnt != '0);
    bypass        = out_load & (mem_cnt == '0) & wr_acc;
    mem_wr        = wr_acc & ~bypass;
    out_valid_nxt = out_load ? (mem_rd | bypass) : out_valid;
  end
`else
  always_comb begin
    mem_rd = rd_acc;
    mem_wr = wr_acc;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      dout        <= '0;
`ifdef FIFO_BANK_FWFT_EN
      out_valid   <= 1'b0;
`endif
    end else begin
      count       <= count_nxt;
      full        <= (count_nxt == DEPTH_C);
      almost_full <= (count_nxt >= AF_C);
      if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
      if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
      overflow    <= (wr_en & full)  | (overflow  & ~err_clr);
      underflow   <= (rd_en & empty) | (underflow & ~err_clr);
`ifdef FIFO_BANK_FWFT_EN
      out_valid   <= out_valid_nxt;
      empty       <= ~out_valid_nxt;
      if (mem_rd)      dout <= mem[rd_ptr];
      else if (bypass) dout <= din;
`else
      empty       <= (count_nxt == '0);
      if (mem_rd) dout <= mem[rd_ptr];
`endif
    end
  end

  // Storage is never cleared; reset only blocks writes in its cycle.
  always_ff @(posedge clk) begin
    if (reset && mem_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: tb/tb_fifo_bank.sv
module tb_fifo_bank;

  localparam int CH = 2;
  localparam int DW = 32;
  localparam int DP = 16;
  localparam int AF = 14;

  logic            clk = 1'b0;
  logic            reset;
  logic            wr_en;
  logic [CH*DW-1:0] din;
  logic            full;
  logic            almost_full;
  logic            rd_en;
  logic [CH*DW-1:0] dout;
  logic            empty;
  logic [4:0]      count;
  logic            err_clr;
  logic            overflow;
  logic            underflow;

  int checks = 0;
  int errors = 0;

  fifo_bank #(
    .CHANNELS(CH),
    .DATA_WIDTH(DW),
    .DEPTH(DP),
    .AF_THRESH(AF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .din(din),
    .full(full),
    .almost_full(almost_full),
    .rd_en(rd_en),
    .dout(dout),
    .empty(empty),
    .count(count),
    .err_clr(err_clr),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pair(input int unsigned a, input int unsigned b);
    return {b[31:0], a[31:0]};
  endfunction

  initial begin
    reset = 1'b0; wr_en = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    din = pair(32'hAAAA, 32'hBBBB);
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    reset = 1'b1; wr_en = 1'b0;

`ifdef FIFO_BANK_FWFT_EN
    din = {32'h0BADF00D, 32'hDEADBEEF}; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("fwft_empty", empty, 0);
    chk("fwft_dout", dout, {32'h0BADF00D, 32'hDEADBEEF});
    chk("fwft_count", count, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("fwft_empty2", empty, 1);
    chk("fwft_count2", count, 0);
    chk("fwft_hold", dout, {32'h0BADF00D, 32'hDEADBEEF});
    chk("fwft_udf", underflow, 0);
    // three entries, then acknowledge one at a time
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = pair(32'h50 + i, 32'h60 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("fwft3_count", count, 3);
    chk("fwft3_head", dout, pair(32'h50, 32'h60));
    rd_en = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      chk("fwft3_next", dout, pair(32'h50 + i, 32'h60 + i));
    end
    tick();
    rd_en = 1'b0;
    chk("fwft3_empty", empty, 1);
    // full capacity is DEPTH
    wr_en = 1'b1;
    for (int i = 0; i < DP; i++) begin
      din = pair(i, 32'h1000 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("fwft_full", full, 1);
    chk("fwft_full_cnt", count, 16);
    rd_en = 1'b1;
    for (int i = 0; i < DP; i++) begin
      chk("fwft_drain", dout, pair(i, 32'h1000 + i));
      tick();
    end
    rd_en = 1'b0;
    chk("fwft_drain_empty", empty, 1);
`else
    // fill
    wr_en = 1'b1;
    for (int i = 0; i < DP; i++) begin
      din = pair(i, 32'h1000 + i);
      tick();
      chk("fill_count", count, i + 1);
      chk("fill_af", almost_full, (i + 1 >= AF) ? 1 : 0);
      chk("fill_full", full, (i + 1 == DP) ? 1 : 0);
      chk("fill_empty", empty, 0);
    end
    // overflow: rejected write must not disturb entry 0
    din = pair(32'hDEAD, 32'hBEEF);
    tick();
    wr_en = 1'b0;
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_full", full, 1);
    // drain
    rd_en = 1'b1;
    for (int i = 0; i < DP; i++) begin
      tick();
      chk("drain_data", dout, pair(i, 32'h1000 + i));
      chk("drain_count", count, 15 - i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_af", almost_full, 0);
    chk("drain_udf_clear", underflow, 0);
    // underflow on empty, dout holds
    tick();
    rd_en = 1'b0;
    chk("udf_flag", underflow, 1);
    chk("udf_hold", dout, pair(15, 32'h100F));
    chk("udf_count", count, 0);
    // error clear
    err_clr = 1'b1;
    tick();
    chk("clr_ovf", overflow, 0);
    chk("clr_udf", underflow, 0);
    // set wins over clear
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0; err_clr = 1'b0;
    chk("setwin_udf", underflow, 1);
    chk("setwin_ovf", overflow, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr2_udf", underflow, 0);

    // simultaneous access at count 5
    wr_en = 1'b1;
    for (int j = 0; j < 5; j++) begin
      din = pair(32'h100 + j, 32'h2000 + j);
      tick();
    end
    chk("sim5_count", count, 5);
    rd_en = 1'b1;
    for (int j = 5; j < 15; j++) begin
      din = pair(32'h100 + j, 32'h2000 + j);
      tick();
      chk("sim5_data", dout, pair(32'h100 + j - 5, 32'h2000 + j - 5));
      chk("sim5_cnt", count, 5);
    end
    wr_en = 1'b0;
    for (int j = 10; j < 15; j++) begin
      tick();
      chk("sim5_tail", dout, pair(32'h100 + j, 32'h2000 + j));
    end
    rd_en = 1'b0;
    chk("sim5_empty", empty, 1);

    // simultaneous access at full: read wins, write rejected
    wr_en = 1'b1;
    for (int j = 0; j < DP; j++) begin
      din = pair(32'h300 + j, 32'h3000 + j);
      tick();
    end
    chk("simf_full", full, 1);
    rd_en = 1'b1;
    din = pair(32'hBAD, 32'hBAD);
    tick();
    wr_en = 1'b0;
    chk("simf_count", count, 15);
    chk("simf_ovf", overflow, 1);
    chk("simf_data", dout, pair(32'h300, 32'h3000));
    chk("simf_notfull", full, 0);
    for (int j = 1; j < DP; j++) begin
      tick();
      chk("simf_drain", dout, pair(32'h300 + j, 32'h3000 + j));
    end
    rd_en = 1'b0;
    chk("simf_empty", empty, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // wrap-around at occupancy 3
    wr_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      din = pair(32'h400 + j, 32'h4000 + j);
      tick();
    end
    rd_en = 1'b1;
    for (int j = 0; j < 40; j++) begin
      din = pair(32'h403 + j, 32'h4003 + j);
      tick();
      chk("wrap_data", dout, pair(32'h400 + j, 32'h4000 + j));
      chk("wrap_cnt", count, 3);
    end
    wr_en = 1'b0;
    for (int j = 40; j < 43; j++) begin
      tick();
      chk("wrap_tail", dout, pair(32'h400 + j, 32'h4000 + j));
    end
    rd_en = 1'b0;
    chk("wrap_empty", empty, 1);
    chk("wrap_ovf", overflow, 0);
    chk("wrap_udf", underflow, 0);
`endif

    // mid-stream reset discards data
    wr_en = 1'b1; din = pair(32'h77, 32'h88);
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; wr_en = 1'b0;
    chk("rst2_count", count, 0);
    chk("rst2_empty", empty, 1);
    chk("rst2_dout", dout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_bank.md
Name: fifo_bank

Overview:
- Parametrised, single-clock, multi-channel lock-step FIFO. Successor to the per-signal fifo instances that link FM pipeline stages.
- One instance carries a paired stream with a single shared handshake: I/Q into fir_complex, or left/right out of the gain stages. Both lanes therefore can never drift apart by a sample.
- Adds occupancy count, almost-full watermark, sticky overflow/underflow error flags and an optional first-word-fall-through read mode.

Parameters:
- CHANNELS, 2, number of lanes sharing one handshake (>=1).
- DATA_WIDTH, 32, bits per lane.
- DEPTH, 16, entries per lane; power of two, >=4.
- AF_THRESH, DEPTH-2, count at or above which almost_full asserts (1..DEPTH).

Ports:
- clk  in  1  Sole clock; all state updates on its rising edge.
- reset  in  1  Synchronous, active-low reset. Sampled on the rising clk edge; 0 = reset.
- wr_en  in  1  Write request, all lanes.
- din  in  CHANNELS*DATA_WIDTH  Write data; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- rd_en  in  1  Read request (acknowledge in FWFT mode).
- dout  out  CHANNELS*DATA_WIDTH  Read data, same lane packing as din.
- empty  out  1  No readable data.
- count  out  $clog2(DEPTH)+1  Stored entries.
- err_clr  in  1  Clears sticky error flags.
- overflow  out  1  Sticky: write attempted while full.
- underflow  out  1  Sticky: read attempted while empty.

Behaviour:
- Reset (reset==0 at a clk edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, almost_full=0, overflow=0, underflow=0, dout=0.
  - Memory contents are not cleared.
  - Reset overrides all same-cycle wr_en/rd_en/err_clr. Asserting reset mid-stream discards all stored data.
- Write accept: wr_acc = wr_en & ~full.
  - All CHANNELS lanes are written at wr_ptr in the same edge.
  - wr_ptr increments modulo DEPTH (natural wrap at pointer width).
- Read accept: rd_acc = rd_en & ~empty. rd_ptr increments modulo DEPTH.
- Count update:
  - +1 on wr_acc only; -1 on rd_acc only.
  - Unchanged when both accept in the same cycle.
  - Simultaneous read and write on a full FIFO: the read is accepted and the write is rejected (full gates it). Count goes DEPTH-1, and overflow sets.
  - Simultaneous read and write on an empty FIFO: the write is accepted and the read is rejected. underflow sets.
- Flag timing: full, almost_full, empty and count are all registered and reflect the state after the edge. No combinational path from wr_en/rd_en to any flag.
- Errors:
  - overflow <= 1 when wr_en & full; underflow <= 1 when rd_en & empty (the empty flag as seen in the current mode).
  - err_clr clears both flags. If a new error event occurs in the same cycle as err_clr, the set wins.
- Rejected accesses never modify pointers, count or memory.
- Standard read mode (FWFT_EN undefined):
  - dout is registered; it updates 1 cycle after rd_acc with mem[rd_ptr] and holds its value otherwise.
  - empty is 1 iff count==0.
- Data integrity: lanes are never reordered or split; entry n of lane k always pairs with entry n of every other lane.

Optional Feature:
- Macro FIFO_BANK_FWFT_EN.
- Defined (first-word fall-through):
  - An output register stage presents the head entry on dout without a read request.
  - empty deasserts the cycle after the first write into an empty bank, with valid data on dout in that same cycle.
  - rd_en acts as acknowledge: on rd_acc the next entry, if any, appears on dout the following cycle. Otherwise empty reasserts and dout holds its last value.
  - count includes the entry held in the output stage.
  - Usable capacity stays DEPTH.
- Undefined: standard registered read as described above.

Test Plan:
- Reset: drive reset=0 for 2 cycles with wr_en=1 -> count=0, empty=1, full=0, dout=0, overflow=0.
- Fill/drain, CHANNELS=2, DEPTH=16: write lane0=i, lane1=0x1000+i for i=0..15 -> almost_full at count 14, full at 16. Then read 16 -> pairs returned in order (0,0x1000)...(15,0x100F), then empty=1.
- Overflow/underflow:
  - With full=1, pulse wr_en -> count stays 16, memory unchanged, overflow=1.
  - Drain, then pulse rd_en on empty -> underflow=1.
  - err_clr -> both flags 0.
- Simultaneous access:
  - At count=5, wr_en=rd_en=1 for 10 cycles -> count stays 5, data order preserved.
  - Same at full -> count 15, overflow=1.
- Wrap-around: push/pop 40 entries keeping occupancy 3 -> all values match; pointers wrap twice with no corruption.
- FWFT (macro defined): single write of 0xDEADBEEF/0x0BADF00D into empty bank -> next cycle empty=0 and dout shows both words with no rd_en. rd_en for 1 cycle -> empty=1 the following cycle.
